// File: rtl/pmu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pmu_pkg : shared state encoding and sizing helpers for the PMU sequencer
// Revision 1.0
// ----------------------------------------------------------------------------
package pmu_pkg;

  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_UP_SETTLE  = 3'd1,
    ST_UP_WAIT_PG = 3'd2,
    ST_ON         = 3'd3,
    ST_DOWN       = 3'd4,
    ST_FAULT      = 3'd5
  } pmu_state_t;

  localparam int FAULT_CH_W_MIN = 1;

  // Channel-index width; a single-bit index is kept even for tiny banks.
  function automatic int fault_ch_width(input int n_ch);
    return (n_ch > 2) ? $clog2(n_ch) : FAULT_CH_W_MIN;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pmu_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pmu_sync : multi-bit, multi-stage flop synchronizer with async active-low reset
// Revision 1.0
// ----------------------------------------------------------------------------
module pmu_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stage[0] <= '0;
    else        r_stage[0] <= d;
  end

  generate
    for (genvar g = 1; g < STAGES; g++) begin : g_stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_stage[g] <= '0;
        else        r_stage[g] <= r_stage[g-1];
      end
    end
  endgenerate

  assign q = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pmu_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pmu_sequencer : ordered regulator enable/disable sequencer with power-good fault
// Revision 1.0
// ----------------------------------------------------------------------------
module pmu_sequencer
  import pmu_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pwr_req,
  input  logic [CNT_W-1:0]         settle_cycles,
  input  logic [CNT_W-1:0]         timeout_cycles,
  input  logic [N_CH-1:0]          pg_i,
  input  logic                     clr_fault,
  output logic [N_CH-1:0]          en_o,
  output logic                     busy,
  output logic                     ready,
  output logic                     fault,
  output logic [$clog2(N_CH)-1:0]  fault_ch
);

  localparam int IDX_W = fault_ch_width(N_CH);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_CH - 1);
  localparam logic [N_CH-1:0]  c_one      = N_CH'(1);

  pmu_state_t       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [N_CH-1:0]  r_en;
  logic             r_fault;
  logic [IDX_W-1:0] r_fault_ch;

  logic [N_CH-1:0]  w_pg_s;
  logic [CNT_W-1:0] w_settle_last;
  logic [IDX_W-1:0] w_idx_inc;
  logic [IDX_W-1:0] w_idx_dec;
  logic             w_pg_bad;
  logic [IDX_W-1:0] w_bad_idx;

  pmu_sync #(
    .WIDTH  (N_CH),
    .STAGES (SYNC_STAGES)
  ) u_pg_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pg_i),
    .q     (w_pg_s)
  );

  // A zero settle time is treated as a single cycle.
  assign w_settle_last = (settle_cycles == '0) ? '0 : settle_cycles - CNT_W'(1);
  assign w_idx_inc     = r_idx + IDX_W'(1);
  assign w_idx_dec     = r_idx - IDX_W'(1);

  always_comb begin
    w_pg_bad  = 1'b0;
    w_bad_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (!w_pg_s[i]) begin
        w_pg_bad  = 1'b1;
        w_bad_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_OFF;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_en       <= '0;
      r_fault    <= 1'b0;
      r_fault_ch <= '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          r_en <= '0;
          if (pwr_req) begin
            r_en    <= c_one;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_state <= ST_UP_SETTLE;
          end
        end

        ST_UP_SETTLE: begin
          if (!pwr_req) begin
            r_en    <= r_en & ~(c_one << r_idx);
            r_cnt   <= '0;
            r_state <= ST_DOWN;
          end else if (r_cnt >= w_settle_last) begin
            r_cnt   <= '0;
            r_state <= ST_UP_WAIT_PG;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        // Request drop outranks both success and timeout; success outranks timeout.
        ST_UP_WAIT_PG: begin
          if (!pwr_req) begin
            r_en    <= r_en & ~(c_one << r_idx);
            r_cnt   <= '0;
            r_state <= ST_DOWN;
          end else if (w_pg_s[r_idx]) begin
            if (r_idx == c_last_idx) begin
              r_state <= ST_ON;
            end else begin
              r_idx   <= w_idx_inc;
              r_en    <= r_en | (c_one << w_idx_inc);
              r_cnt   <= '0;
              r_state <= ST_UP_SETTLE;
            end
          end else if (r_cnt >= timeout_cycles) begin
            r_en       <= '0;
            r_fault    <= 1'b1;
            r_fault_ch <= r_idx;
            r_state    <= ST_FAULT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_ON: begin
          if (w_pg_bad) begin
            r_en       <= '0;
            r_fault    <= 1'b1;
            r_fault_ch <= w_bad_idx;
            r_state    <= ST_FAULT;
          end else if (!pwr_req) begin
            r_idx   <= c_last_idx;
            r_en    <= r_en & ~(c_one << c_last_idx);
            r_cnt   <= '0;
            r_state <= ST_DOWN;
          end
        end

        ST_DOWN: begin
          if (r_cnt >= w_settle_last) begin
            r_cnt <= '0;
            if (r_idx == '0) begin
              r_state <= ST_OFF;
            end else begin
              r_idx <= w_idx_dec;
              r_en  <= r_en & ~(c_one << w_idx_dec);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_FAULT: begin
          r_en <= '0;
          if (clr_fault && !pwr_req) begin
            r_fault <= 1'b0;
            r_state <= ST_OFF;
          end
        end

        default: begin
          r_en    <= '0;
          r_state <= ST_OFF;
        end
      endcase
    end
  end

  assign en_o     = r_en;
  assign busy     = (r_state == ST_UP_SETTLE) || (r_state == ST_UP_WAIT_PG) || (r_state == ST_DOWN);
  assign ready    = (r_state == ST_ON);
  assign fault    = r_fault;
  assign fault_ch = r_fault_ch;

endmodule
`default_nettype wire

// File: tb/tb_pmu_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pmu_sequencer : randomized bench against a time-stamp based sequencing model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_pmu_sequencer;

  localparam int N_CH        = 4;
  localparam int CNT_W       = 16;
  localparam int SYNC_STAGES = 2;
  localparam int IDX_W       = $clog2(N_CH);

  localparam int MD_OFF   = 0;
  localparam int MD_RISE  = 1;
  localparam int MD_ON    = 2;
  localparam int MD_FALL  = 3;
  localparam int MD_FAULT = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pwr_req = 1'b0;
  logic             clr_fault = 1'b0;
  logic [CNT_W-1:0] settle_cycles = 16'd3;
  logic [CNT_W-1:0] timeout_cycles = 16'd10;
  logic [N_CH-1:0]  pg_i = '0;
  logic [N_CH-1:0]  en_o;
  logic             busy;
  logic             ready;
  logic             fault;
  logic [IDX_W-1:0] fault_ch;

  pmu_sequencer #(
    .N_CH        (N_CH),
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pwr_req        (pwr_req),
    .settle_cycles  (settle_cycles),
    .timeout_cycles (timeout_cycles),
    .pg_i           (pg_i),
    .clr_fault      (clr_fault),
    .en_o           (en_o),
    .busy           (busy),
    .ready          (ready),
    .fault          (fault),
    .fault_ch       (fault_ch)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: mode, number of low channels enabled, active channel and the edge
  // number at which that channel's last enable/disable happened.
  int  m_mode, m_n, m_c, m_t, m_fch, edge_no;
  bit  m_fault;
  logic [N_CH-1:0] pgq[$];
  logic [N_CH-1:0] enq[$];
  logic [N_CH-1:0] kill = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N_CH-1:0] model_en();
    return N_CH'((1 << m_n) - 1);
  endfunction

  function automatic logic [2:0] mode_flags(input int md);
    case (md)
      MD_RISE, MD_FALL: return 3'b100;
      MD_ON:            return 3'b010;
      MD_FAULT:         return 3'b001;
      default:          return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = MD_OFF; m_n = 0; m_c = 0; m_t = 0; m_fault = 0; m_fch = 0;
    pgq = {};
    enq = {};
    for (int i = 0; i < SYNC_STAGES; i++) pgq.push_back('0);
    for (int i = 0; i < 2; i++) enq.push_back('0);
  endtask

  task automatic go_fault(input int ch);
    m_mode = MD_FAULT; m_fault = 1; m_fch = ch; m_n = 0;
  endtask

  task automatic model_step();
    logic [N_CH-1:0] pg_s;
    int s, to, e;
    edge_no++;
    e    = edge_no;
    pg_s = pgq.pop_front();
    pgq.push_back(pg_i);
    s  = (settle_cycles == 0) ? 1 : int'(settle_cycles);
    to = int'(timeout_cycles);
    case (m_mode)
      MD_OFF: if (pwr_req) begin m_mode = MD_RISE; m_c = 0; m_n = 1; m_t = e; end
      MD_RISE: begin
        if (!pwr_req) begin
          m_mode = MD_FALL; m_n = m_c; m_t = e;
        end else if (e > m_t + s) begin
          if (pg_s[m_c]) begin
            if (m_c == N_CH - 1) m_mode = MD_ON;
            else begin m_c++; m_n = m_c + 1; m_t = e; end
          end else if (e >= m_t + s + to + 1) begin
            go_fault(m_c);
          end
        end
      end
      MD_ON: begin
        if (pg_s != {N_CH{1'b1}}) begin
          int low = 0;
          for (int i = N_CH - 1; i >= 0; i--) if (!pg_s[i]) low = i;
          go_fault(low);
        end else if (!pwr_req) begin
          m_mode = MD_FALL; m_c = N_CH - 1; m_n = m_c; m_t = e;
        end
      end
      MD_FALL: if (e >= m_t + s) begin
        if (m_c == 0) m_mode = MD_OFF;
        else begin m_c--; m_n = m_c; m_t = e; end
      end
      default: if (clr_fault && !pwr_req) begin m_mode = MD_OFF; m_fault = 0; end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    enq.push_back(model_en());
    void'(enq.pop_front());
    #1;
    check_val("en_o", en_o, model_en());
    check_val("flags", {busy, ready, fault}, mode_flags(m_mode));
    if (m_fault) check_val("fault_ch", fault_ch, m_fch);
    pg_i = enq[0] & ~kill;
  endtask

  task automatic wait_mode(input int md, input int budget, input string tag);
    int k = 0;
    while (m_mode != md && k < budget) begin step(); k++; end
    check_val(tag, {busy, ready, fault}, mode_flags(md));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    edge_no = 0;
    model_reset();
    #12;
    check_val("rst_en", en_o, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ready", ready, 0);
    check_val("rst_fault", fault, 0);
    check_val("rst_fch", fault_ch, 0);
    rst_n = 1'b1;

    pwr_req = 1'b1;
    wait_mode(MD_ON, 100, "up_ready");
    check_val("up_en_all", en_o, 4'b1111);
    pwr_req = 1'b0;
    wait_mode(MD_OFF, 100, "down_off");

    kill = 4'b0100;
    pwr_req = 1'b1;
    wait_mode(MD_FAULT, 100, "pg2_fault");
    check_val("pg2_fch", fault_ch, 2);
    check_val("pg2_en", en_o, 0);
    clr_fault = 1'b1;
    repeat (3) step();
    check_val("clr_ignored", fault, 1);
    pwr_req = 1'b0;
    step();
    clr_fault = 1'b0;
    check_val("clr_done", fault, 0);
    kill = '0;

    pwr_req = 1'b1;
    wait_mode(MD_ON, 100, "on_again");
    kill = 4'b1010;
    wait_mode(MD_FAULT, 10, "on_fault");
    check_val("on_fch", fault_ch, 1);
    pwr_req = 1'b0; clr_fault = 1'b1;
    step();
    clr_fault = 1'b0; kill = '0;

    pwr_req = 1'b1;
    k = 0;
    while (m_n < 2 && k < 50) begin step(); k++; end
    check_val("early_en", en_o, 4'b0011);
    pwr_req = 1'b0;
    wait_mode(MD_OFF, 50, "early_off");

    settle_cycles = '0;
    pwr_req = 1'b1;
    wait_mode(MD_ON, 100, "s0_ready");
    pwr_req = 1'b0;
    wait_mode(MD_OFF, 100, "s0_off");

    settle_cycles = 16'd3;
    pwr_req = 1'b1;
    repeat (8) step();
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_en", en_o, 0);
    check_val("arst_busy", busy, 0);
    model_reset();
    pwr_req = 1'b0; pg_i = '0;
    #2 rst_n = 1'b1;
    step();

    for (int ep = 0; ep < 30; ep++) begin
      pwr_req = 1'b0; clr_fault = 1'b1; kill = '0;
      wait_mode(MD_OFF, 200, "rnd_idle");
      clr_fault = 1'b0;
      settle_cycles  = CNT_W'($urandom_range(0, 4));
      timeout_cycles = CNT_W'($urandom_range(0, 8));
      for (int c = 0; c < 80; c++) begin
        if ($urandom_range(0, 15) == 0) pwr_req = ~pwr_req;
        clr_fault = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 39) == 0) kill = N_CH'($urandom);
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
